bicubic_window_ctrl: RTL
========================

# bicubic_window_ctrl

Sequencer for the bicubic 4x4 window buffer: the line buffers and shift registers that feed the interpolator. It owns the fill, run, row-flush and end-of-frame phases of one upscaled frame. It also generates the window shift enable, the source-pixel handshake and the window-valid handshake toward the interpolator, and it tracks the sub-pixel phase, column and row. It sits between the AXI-stream source and the window buffer/interpolator pair.

## Interface
- IMG_WIDTH, 960, source pixels per row
- IMG_HEIGHT, 540, source rows per frame
- PHASES, 16, interpolator outputs per window position; legal values 1/2/4/8/16
- PAD_COLS, 3, flush shifts per row after the last real column
- FILL_COUNT, 3*IMG_WIDTH+14, source shifts needed to prime the window before the first output
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  one-cycle frame start pulse, accepted only in IDLE
- src_valid  in  1  source pixel available
- src_ready  out  1  controller accepts the source pixel this cycle
- shift_en  out  1  window/line-buffer shift strobe, equal to src_valid & src_ready
- win_valid  out  1  window contents are valid for the interpolator
- win_ready  in  1  interpolator accepts the current phase
- phase  out  max(1,clog2(PHASES))  sub-pixel phase index
- col  out  10  window column counter, 0..IMG_WIDTH+PAD_COLS-1
- row  out  10  window row counter, 0..IMG_HEIGHT-1
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse when the frame completes

## Operation
- States: IDLE -> FILL -> RUN <-> FLUSH -> DONE -> IDLE.
- IDLE:
  - All counters are 0, src_ready=0, win_valid=0.
  - start moves to FILL.
- FILL:
  - src_ready=1.
  - Fill counter increments on each shift_en.
  - On the shift that brings the count to FILL_COUNT, go to RUN with col=0, row=0, phase=0.
- RUN (col<IMG_WIDTH):
  - Handshake hsk = win_valid & win_ready.
  - phase≠PHASES-1: win_valid=1, src_ready=0, no shift. hsk increments phase.
  - phase=PHASES-1: win_valid=src_valid and src_ready=win_ready, so the last phase consumes a source pixel. On hsk: phase->0, col+1, shift.
  - If col reaches IMG_WIDTH and row=IMG_HEIGHT-1, go to DONE. Otherwise go to FLUSH.
- FLUSH (IMG_WIDTH ≤ col < IMG_WIDTH+PAD_COLS):
  - win_valid=0, src_ready=1.
  - Each shift increments col.
  - On the shift at col=IMG_WIDTH+PAD_COLS-1: col->0, row+1, back to RUN.
- DONE: frame_done=1 for one cycle, then IDLE.
- PHASES=1: phase is held at 0, and every hsk is a last-phase handshake.
- start outside IDLE is ignored.
- Counter arithmetic is unsigned. col and row never exceed their stated ranges.

## Timing
- Reset: state=IDLE. src_ready, shift_en, win_valid, busy and frame_done are 0. phase, col and row are 0.
- Reset asserted mid-frame aborts the frame. The next cycle is IDLE and no frame_done is produced.
- State, counters and frame_done are registered.
- src_ready, win_valid and shift_en are combinational from state, counters, src_valid and win_ready. There is no path from src_ready to src_valid.
- start -> busy=1 on the next cycle. The first src_ready is in that same cycle.
- First win_valid occurs the cycle after the FILL_COUNT-th shift.
- FLUSH->RUN and RUN->FLUSH transitions take zero bubble cycles.
- Back-pressure: in RUN at the last phase, win_ready=0 or src_valid=0 holds phase and col and produces no shift.

## Configuration
- WIN_EDGE_FLAG_EN is defined:
  - Adds outputs edge_left (col==0), edge_right (col==IMG_WIDTH-1), edge_top (row==0) and edge_bot (row==IMG_HEIGHT-1).
  - Each flag is 1 bit, combinational, and gated by win_valid. The interpolator uses them for border replication.
- WIN_EDGE_FLAG_EN is undefined: these ports do not exist and behaviour is otherwise identical.

## Structure
- Shared package bicubic_pkg holds:
  - state encoding (IDLE/FILL/RUN/FLUSH/DONE)
  - default IMG_WIDTH/IMG_HEIGHT
  - a phase-width helper function
- Sub-module bicubic_wrap_cnt: a generic load-enable counter with wrap value and wrap pulse. It is instanced for phase, col and the fill count.
- row is a plain register in the top level.

## Test plan
All scenarios use IMG_WIDTH=11, IMG_HEIGHT=6, PHASES=4, FILL_COUNT=47 unless stated.

- Fill: start, src_valid=1 constant -> exactly 47 shifts, win_valid first high the cycle after shift 47, phase=0 col=0 row=0.
- Full frame, win_ready=1, src_valid=1 -> per row: 44 win handshakes, then 3 flush shifts. Frame totals 264 win handshakes, frame_done exactly once, then IDLE with busy=0.
- Back-pressure: toggle win_ready and drop src_valid at phase=3 -> no shift and no col change while either is low. Phase order 0,1,2,3 is preserved. Output count matches the unstalled run.
- Row wrap: at col=13 the flush shift gives col=0 and row+1, with no win_valid bubble beyond the stall cycles.
- Reset/start: rst at row=2 col=5 -> next cycle IDLE, counters 0, no frame_done. start during RUN has no effect.
- PHASES=1 plus WIN_EDGE_FLAG_EN: one shift per win handshake in RUN. edge_left/right/top/bot are asserted exactly at col 0/10 and row 0/5.

Source files
------------

// File: rtl/bicubic_pkg.sv
// bicubic_pkg
//   Shared definitions for the bicubic window controller:
//   - state_e   : sequencer state encoding (IDLE/FILL/RUN/FLUSH/DONE)
//   - DEF_*     : default frame geometry and phase count
//   - CNT_W     : width of the column/row counters
//   - phase_w() : width of the phase index for a given phase count
package bicubic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_RUN   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int DEF_IMG_WIDTH  = 960;
  localparam int DEF_IMG_HEIGHT = 540;
  localparam int DEF_PHASES     = 16;
  localparam int DEF_PAD_COLS   = 3;
  localparam int CNT_W          = 10;

  // A single-phase interpolator still needs a 1-bit phase port.
  function automatic int phase_w(input int phases);
    if (phases > 1) begin
      return $clog2(phases);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/bicubic_wrap_cnt.sv
// bicubic_wrap_cnt
//   Generic enable counter that returns to zero after reaching WRAP_VAL.
//   Ports:
//     clk_i   clock
//     rst_i   synchronous active-high reset (count -> 0)
//     clr_i   synchronous clear, has priority over en_i
//     en_i    count enable
//     cnt_o   current count
//     wrap_o  combinational pulse: en_i while the count equals WRAP_VAL
module bicubic_wrap_cnt #(
  parameter int           W        = 4,
  parameter logic [W-1:0] WRAP_VAL = '1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear, wrap to zero, increment or hold.
  always_comb begin
    wrap_o = en_i && (cnt_q == WRAP_VAL);
    if (clr_i) begin
      cnt_d = '0;
    end else if (wrap_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/bicubic_window_ctrl.sv
// bicubic_window_ctrl
//   Sequencer for the bicubic 4x4 window buffer: primes the line buffers
//   (FILL), emits PHASES interpolator outputs per source column (RUN),
//   pushes PAD_COLS flush shifts at each row end (FLUSH) and signals the
//   end of the frame (DONE).
//   Ports:
//     clk_i, rst_i            clock, synchronous active-high reset
//     start_i                 frame start pulse (honoured only in IDLE)
//     src_valid_i/src_ready_o source pixel handshake
//     shift_en_o              window shift strobe = src_valid_i & src_ready_o
//     win_valid_o/win_ready_i window handshake toward the interpolator
//     phase_o, col_o, row_o   sub-pixel phase, window column, window row
//     busy_o                  high outside IDLE
//     frame_done_o            one-cycle pulse at end of frame
//   Optional feature macro WIN_EDGE_FLAG_EN adds edge_left_o, edge_right_o,
//   edge_top_o and edge_bot_o (border flags gated by win_valid_o).
module bicubic_window_ctrl
  import bicubic_pkg::*;
#(
  parameter int  IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int  IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int  PHASES     = DEF_PHASES,
  parameter int  PAD_COLS   = DEF_PAD_COLS,
  parameter int  FILL_COUNT = 3*IMG_WIDTH+14,
  localparam int PW         = phase_w(PHASES)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             src_valid_i,
  output logic             src_ready_o,
  output logic             shift_en_o,
  output logic             win_valid_o,
  input  logic             win_ready_i,
  output logic [PW-1:0]    phase_o,
  output logic [CNT_W-1:0] col_o,
  output logic [CNT_W-1:0] row_o,
  output logic             busy_o,
  output logic             frame_done_o
`ifdef WIN_EDGE_FLAG_EN
  ,
  output logic             edge_left_o,
  output logic             edge_right_o,
  output logic             edge_top_o,
  output logic             edge_bot_o
`endif
);

  localparam int FW = (FILL_COUNT > 1) ? $clog2(FILL_COUNT) : 1;

  state_e           state_q;
  state_e           state_d;
  logic             frame_done_q;
  logic [CNT_W-1:0] row_q;
  logic [CNT_W-1:0] row_d;

  logic             src_ready_s;
  logic             win_valid_s;
  logic             shift_s;
  logic             hsk_s;
  logic [PW-1:0]    phase_s;
  logic             phase_last_s;
  logic             phase_wrap_s;
  logic [CNT_W-1:0] col_s;
  logic             col_wrap_s;
  logic             col_last_s;
  logic             row_last_s;
  logic [FW-1:0]    fill_cnt_s;
  logic             fill_wrap_s;
  logic             fill_cnt_unused_s;

  assign shift_s      = src_valid_i & src_ready_s;
  assign hsk_s        = win_valid_s & win_ready_i;
  assign phase_last_s = (phase_s == PW'(PHASES-1));
  assign col_last_s   = (col_s == CNT_W'(IMG_WIDTH-1));
  assign row_last_s   = (row_q == CNT_W'(IMG_HEIGHT-1));
  assign fill_cnt_unused_s = ^fill_cnt_s;

  // Priming counter: wraps on the FILL_COUNT-th shift, which ends FILL.
  bicubic_wrap_cnt #(
    .W        (FW),
    .WRAP_VAL (FW'(FILL_COUNT-1))
  ) u_fill_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (state_q != ST_FILL),
    .en_i   ((state_q == ST_FILL) && shift_s),
    .cnt_o  (fill_cnt_s),
    .wrap_o (fill_wrap_s)
  );

  // Phase counter: its wrap pulse is the last-phase handshake (every
  // handshake when PHASES=1, as the counter then sits at 0).
  bicubic_wrap_cnt #(
    .W        (PW),
    .WRAP_VAL (PW'(PHASES-1))
  ) u_phase_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (state_q != ST_RUN),
    .en_i   ((state_q == ST_RUN) && hsk_s),
    .cnt_o  (phase_s),
    .wrap_o (phase_wrap_s)
  );

  // Column counter spans real columns and flush columns; it only wraps
  // on the last flush shift of a row.
  bicubic_wrap_cnt #(
    .W        (CNT_W),
    .WRAP_VAL (CNT_W'(IMG_WIDTH+PAD_COLS-1))
  ) u_col_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  ((state_q != ST_RUN) && (state_q != ST_FLUSH)),
    .en_i   (((state_q == ST_RUN) && phase_wrap_s) ||
             ((state_q == ST_FLUSH) && shift_s)),
    .cnt_o  (col_s),
    .wrap_o (col_wrap_s)
  );

  // State and frame-done registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_done_q <= (state_d == ST_DONE);
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_FILL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (fill_wrap_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_RUN: begin
        if (phase_wrap_s && col_last_s) begin
          if (row_last_s) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_FLUSH;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (col_wrap_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs. At the last phase the window output and the source
  // pixel are exchanged together, so each side's valid/ready depends on
  // the other side's input.
  always_comb begin
    src_ready_s = 1'b0;
    win_valid_s = 1'b0;
    case (state_q)
      ST_FILL: begin
        src_ready_s = 1'b1;
      end
      ST_RUN: begin
        if (phase_last_s) begin
          win_valid_s = src_valid_i;
          src_ready_s = win_ready_i;
        end else begin
          win_valid_s = 1'b1;
          src_ready_s = 1'b0;
        end
      end
      ST_FLUSH: begin
        src_ready_s = 1'b1;
      end
      default: begin
        src_ready_s = 1'b0;
        win_valid_s = 1'b0;
      end
    endcase
  end

  // Row advances on the column wrap that ends each flush.
  always_comb begin
    if ((state_q != ST_RUN) && (state_q != ST_FLUSH)) begin
      row_d = '0;
    end else if (col_wrap_s) begin
      row_d = row_q + CNT_W'(1);
    end else begin
      row_d = row_q;
    end
  end

  // Row register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      row_q <= '0;
    end else begin
      row_q <= row_d;
    end
  end

  assign src_ready_o  = src_ready_s;
  assign win_valid_o  = win_valid_s;
  assign shift_en_o   = shift_s;
  assign phase_o      = phase_s;
  assign col_o        = col_s;
  assign row_o        = row_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign frame_done_o = frame_done_q;

`ifdef WIN_EDGE_FLAG_EN
  assign edge_left_o  = win_valid_s && (col_s == CNT_W'(0));
  assign edge_right_o = win_valid_s && col_last_s;
  assign edge_top_o   = win_valid_s && (row_q == CNT_W'(0));
  assign edge_bot_o   = win_valid_s && row_last_s;
`endif

endmodule
